// File: rtl/axi_master_wrapper_pkg.sv
// rtl/axi_master_wrapper_pkg.sv - shared AXI widths, response/burst constants and FSM state type
// Purpose: common definitions for the AXI master wrapper.
// Contents: AXI_*_BITS widths, AXI response codes, INCR burst and 4-byte size
//           encodings, and the state_t enum used by the wrapper FSM.
package axi_master_wrapper_pkg;

   localparam int AXI_ADDR_BITS = 32;
   localparam int AXI_DATA_BITS = 32;
   localparam int AXI_LEN_BITS  = 4;
   localparam int AXI_STRB_BITS = AXI_DATA_BITS / 8;
   localparam int AXI_IDS_BITS  = 4;
   localparam int AXI_SIZE_BITS = 3;

   localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
   localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
   localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

   localparam logic [1:0]               AXI_BURST_INCR = 2'b01;
   localparam logic [AXI_SIZE_BITS-1:0] AXI_SIZE_4B    = 3'b010;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_RADDR,
      ST_RDATA,
      ST_WADDR,
      ST_WDATA,
      ST_WRESP,
      ST_DONE
   } state_t;

endpackage

// File: rtl/axi_master_wrapper.sv
// rtl/axi_master_wrapper.sv - single-outstanding AXI4 master bridging a simple core request port
// Purpose: accepts one core read/write request at a time and runs it as an
//          INCR burst on the AXI AR/R or AW/W/B channels, then pulses core_done
//          with an OKAY/SLVERR completion status.
// Ports:
//   ACLK, ARESETn                 clock, asynchronous active-low reset
//   req_*                         core request (valid/ready, write, addr, len, wstrb)
//   core_wdata/wvalid/wready      core write beat stream
//   core_rdata/rvalid/rlast       core read beat stream (no backpressure)
//   core_done/core_resp           one-cycle completion pulse and response
//   AR*/R*/AW*/W*/B* _M           AXI4 master channels
module axi_master_wrapper
   import axi_master_wrapper_pkg::*;
#(
   parameter logic [AXI_IDS_BITS-1:0]  MASTER_ID  = 4'd0,
   parameter logic [1:0]               BURST_TYPE = AXI_BURST_INCR,
   parameter logic [AXI_SIZE_BITS-1:0] BEAT_SIZE  = AXI_SIZE_4B
) (
   input  logic                      ACLK,
   input  logic                      ARESETn,
   input  logic                      req_valid,
   output logic                      req_ready,
   input  logic                      req_write,
   input  logic [AXI_ADDR_BITS-1:0]  req_addr,
   input  logic [AXI_LEN_BITS-1:0]   req_len,
   input  logic [AXI_STRB_BITS-1:0]  req_wstrb,
   input  logic [AXI_DATA_BITS-1:0]  core_wdata,
   input  logic                      core_wvalid,
   output logic                      core_wready,
   output logic [AXI_DATA_BITS-1:0]  core_rdata,
   output logic                      core_rvalid,
   output logic                      core_rlast,
   output logic                      core_done,
   output logic [1:0]                core_resp,
   output logic [AXI_IDS_BITS-1:0]   ARID_M,
   output logic [AXI_ADDR_BITS-1:0]  ARADDR_M,
   output logic [AXI_LEN_BITS-1:0]   ARLEN_M,
   output logic [AXI_SIZE_BITS-1:0]  ARSIZE_M,
   output logic [1:0]                ARBURST_M,
   output logic                      ARVALID_M,
   input  logic                      ARREADY_M,
   input  logic [AXI_IDS_BITS-1:0]   RID_M,
   input  logic [AXI_DATA_BITS-1:0]  RDATA_M,
   input  logic [1:0]                RRESP_M,
   input  logic                      RLAST_M,
   input  logic                      RVALID_M,
   output logic                      RREADY_M,
   output logic [AXI_IDS_BITS-1:0]   AWID_M,
   output logic [AXI_ADDR_BITS-1:0]  AWADDR_M,
   output logic [AXI_LEN_BITS-1:0]   AWLEN_M,
   output logic [AXI_SIZE_BITS-1:0]  AWSIZE_M,
   output logic [1:0]                AWBURST_M,
   output logic                      AWVALID_M,
   input  logic                      AWREADY_M,
   output logic [AXI_DATA_BITS-1:0]  WDATA_M,
   output logic [AXI_STRB_BITS-1:0]  WSTRB_M,
   output logic                      WLAST_M,
   output logic                      WVALID_M,
   input  logic                      WREADY_M,
   input  logic [AXI_IDS_BITS-1:0]   BID_M,
   input  logic [1:0]                BRESP_M,
   input  logic                      BVALID_M,
   output logic                      BREADY_M
);

   state_t                     state_q, state_d;
   logic [AXI_ADDR_BITS-1:0]   addr_q;
   logic [AXI_LEN_BITS-1:0]    len_q;
   logic [AXI_STRB_BITS-1:0]   wstrb_q;
   logic [AXI_LEN_BITS-1:0]    cnt_q;
   logic                       err_q;

   // Beat counter equal to len marks the final beat; comparing before the
   // increment lets len=15 run 16 beats without the counter wrapping.
   logic last_beat;
   logic r_hs, w_hs, b_hs;

   assign last_beat = (cnt_q == len_q);
   assign r_hs      = (state_q == ST_RDATA) && RVALID_M;
   assign w_hs      = (state_q == ST_WDATA) && core_wvalid && WREADY_M;
   assign b_hs      = (state_q == ST_WRESP) && BVALID_M;

   assign ARID_M     = MASTER_ID;
   assign ARADDR_M   = addr_q;
   assign ARLEN_M    = len_q;
   assign ARSIZE_M   = BEAT_SIZE;
   assign ARBURST_M  = BURST_TYPE;
   assign AWID_M     = MASTER_ID;
   assign AWADDR_M   = addr_q;
   assign AWLEN_M    = len_q;
   assign AWSIZE_M   = BEAT_SIZE;
   assign AWBURST_M  = BURST_TYPE;
   assign WSTRB_M    = wstrb_q;
   assign core_rdata = RDATA_M;

   always_ff @(posedge ACLK or negedge ARESETn) begin
      if (!ARESETn) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      req_ready   = 1'b0;
      ARVALID_M   = 1'b0;
      RREADY_M    = 1'b0;
      AWVALID_M   = 1'b0;
      WVALID_M    = 1'b0;
      WDATA_M     = '0;
      WLAST_M     = 1'b0;
      BREADY_M    = 1'b0;
      core_wready = 1'b0;
      core_rvalid = 1'b0;
      core_rlast  = 1'b0;
      core_done   = 1'b0;
      core_resp   = AXI_RESP_OKAY;
      case (state_q)
         ST_IDLE: begin
            req_ready = 1'b1;
            if (req_valid) begin
               state_d = req_write ? ST_WADDR : ST_RADDR;
            end
         end
         ST_RADDR: begin
            ARVALID_M = 1'b1;
            if (ARREADY_M) begin
               state_d = ST_RDATA;
            end
         end
         ST_RDATA: begin
            RREADY_M    = 1'b1;
            core_rvalid = RVALID_M;
            core_rlast  = RLAST_M;
            // A burst that runs to len+1 beats without RLAST is closed anyway.
            if (RVALID_M && (RLAST_M || last_beat)) begin
               state_d = ST_DONE;
            end
         end
         ST_WADDR: begin
            AWVALID_M = 1'b1;
            if (AWREADY_M) begin
               state_d = ST_WDATA;
            end
         end
         ST_WDATA: begin
            WVALID_M    = core_wvalid;
            WDATA_M     = core_wdata;
            WLAST_M     = last_beat;
            core_wready = WREADY_M;
            if (w_hs && last_beat) begin
               state_d = ST_WRESP;
            end
         end
         ST_WRESP: begin
            BREADY_M = 1'b1;
            if (BVALID_M) begin
               state_d = ST_DONE;
            end
         end
         ST_DONE: begin
            core_done = 1'b1;
            // Any non-OKAY beat sets the error flag, so an un-flagged
            // transaction's last response was necessarily OKAY.
            core_resp = err_q ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
            state_d   = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge ACLK or negedge ARESETn) begin
      if (!ARESETn) begin
         addr_q  <= '0;
         len_q   <= '0;
         wstrb_q <= '0;
         cnt_q   <= '0;
         err_q   <= 1'b0;
      end else begin
         if ((state_q == ST_IDLE) && req_valid) begin
            addr_q  <= req_addr;
            len_q   <= req_len;
            wstrb_q <= req_wstrb;
            cnt_q   <= '0;
            err_q   <= 1'b0;
         end
         if (r_hs) begin
            if ((RRESP_M != AXI_RESP_OKAY) || (RID_M != MASTER_ID) || (last_beat && !RLAST_M)) begin
               err_q <= 1'b1;
            end
            cnt_q <= (RLAST_M || last_beat) ? '0 : cnt_q + 1'b1;
         end
         if (w_hs) begin
            cnt_q <= last_beat ? '0 : cnt_q + 1'b1;
         end
         if (b_hs && ((BRESP_M != AXI_RESP_OKAY) || (BID_M != MASTER_ID))) begin
            err_q <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_axi_master_wrapper.sv
// tb/tb_axi_master_wrapper.sv - self-checking bench for axi_master_wrapper
module tb_axi_master_wrapper;
   import axi_master_wrapper_pkg::*;

   logic                      ACLK = 1'b0;
   logic                      ARESETn;
   logic                      req_valid, req_ready, req_write;
   logic [AXI_ADDR_BITS-1:0]  req_addr;
   logic [AXI_LEN_BITS-1:0]   req_len;
   logic [AXI_STRB_BITS-1:0]  req_wstrb;
   logic [AXI_DATA_BITS-1:0]  core_wdata, core_rdata;
   logic                      core_wvalid, core_wready, core_rvalid, core_rlast, core_done;
   logic [1:0]                core_resp;
   logic [AXI_IDS_BITS-1:0]   ARID_M, RID_M, AWID_M, BID_M;
   logic [AXI_ADDR_BITS-1:0]  ARADDR_M, AWADDR_M;
   logic [AXI_LEN_BITS-1:0]   ARLEN_M, AWLEN_M;
   logic [AXI_SIZE_BITS-1:0]  ARSIZE_M, AWSIZE_M;
   logic [1:0]                ARBURST_M, AWBURST_M, RRESP_M, BRESP_M;
   logic                      ARVALID_M, ARREADY_M, RLAST_M, RVALID_M, RREADY_M;
   logic                      AWVALID_M, AWREADY_M, WLAST_M, WVALID_M, WREADY_M, BVALID_M, BREADY_M;
   logic [AXI_DATA_BITS-1:0]  RDATA_M, WDATA_M;
   logic [AXI_STRB_BITS-1:0]  WSTRB_M;

   int checks = 0;
   int errors = 0;

   axi_master_wrapper dut (
      .ACLK(ACLK), .ARESETn(ARESETn),
      .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
      .req_addr(req_addr), .req_len(req_len), .req_wstrb(req_wstrb),
      .core_wdata(core_wdata), .core_wvalid(core_wvalid), .core_wready(core_wready),
      .core_rdata(core_rdata), .core_rvalid(core_rvalid), .core_rlast(core_rlast),
      .core_done(core_done), .core_resp(core_resp),
      .ARID_M(ARID_M), .ARADDR_M(ARADDR_M), .ARLEN_M(ARLEN_M), .ARSIZE_M(ARSIZE_M),
      .ARBURST_M(ARBURST_M), .ARVALID_M(ARVALID_M), .ARREADY_M(ARREADY_M),
      .RID_M(RID_M), .RDATA_M(RDATA_M), .RRESP_M(RRESP_M), .RLAST_M(RLAST_M),
      .RVALID_M(RVALID_M), .RREADY_M(RREADY_M),
      .AWID_M(AWID_M), .AWADDR_M(AWADDR_M), .AWLEN_M(AWLEN_M), .AWSIZE_M(AWSIZE_M),
      .AWBURST_M(AWBURST_M), .AWVALID_M(AWVALID_M), .AWREADY_M(AWREADY_M),
      .WDATA_M(WDATA_M), .WSTRB_M(WSTRB_M), .WLAST_M(WLAST_M), .WVALID_M(WVALID_M),
      .WREADY_M(WREADY_M),
      .BID_M(BID_M), .BRESP_M(BRESP_M), .BVALID_M(BVALID_M), .BREADY_M(BREADY_M)
   );

   always #5 ACLK = ~ACLK;

   initial begin
      #3000000;
      $display("FAIL watchdog actual=running required=finished");
      $fatal(1);
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic idle_slave();
      ARREADY_M = 0; AWREADY_M = 0; WREADY_M = 0;
      RVALID_M = 0; RLAST_M = 0; RDATA_M = '0; RRESP_M = 2'b00; RID_M = '0;
      BVALID_M = 0; BRESP_M = 2'b00; BID_M = '0;
      core_wvalid = 0; core_wdata = '0;
   endtask

   // Runs one request from acceptance to completion against a behavioural slave.
   // mode: 0 clean, 1 error response, 2 wrong ID, 3 read burst without RLAST.
   // Expected completion: any misbehaviour yields SLVERR, else OKAY.
   // Called and returns just after a rising edge (+1).
   task automatic do_txn(input bit wr, input logic [31:0] addr, input logic [3:0] len,
                         input logic [3:0] strb, input int mode, input logic [1:0] exp_resp,
                         input int abort_at, output bit aborted);
      logic [31:0] dq[$];
      int nb, ph, beat, wait_a, wait_b, bad_beat, cyc;
      aborted  = 0;
      nb       = int'(len) + 1;
      for (int i = 0; i < nb; i++) dq.push_back($urandom);
      wait_a   = $urandom_range(0, 3);
      wait_b   = $urandom_range(0, 3);
      bad_beat = $urandom_range(0, nb - 1);
      idle_slave();
      req_valid = 1; req_write = wr; req_addr = addr; req_len = len; req_wstrb = strb;
      ph = 0; beat = 0; cyc = 0;
      while (ph != 5 && cyc < 400) begin
         @(negedge ACLK);
         cyc++;
         case (ph)
            0: begin
               chk("req_ready_idle", req_ready, 1);
               chk("no_valid_before_accept", {ARVALID_M, AWVALID_M}, 0);
               ph = 1;
            end
            1: begin
               chk("done_low_addr", core_done, 0);
               if (wr) begin
                  chk("awvalid", AWVALID_M, 1);
                  chk("awaddr", AWADDR_M, addr);
                  chk("awlen", AWLEN_M, len);
                  chk("awsize_burst_id", {AWSIZE_M, AWBURST_M, AWID_M}, {3'b010, 2'b01, 4'd0});
                  chk("no_w_before_aw", WVALID_M, 0);
                  if (AWREADY_M) ph = 2;
               end else begin
                  chk("arvalid", ARVALID_M, 1);
                  chk("araddr", ARADDR_M, addr);
                  chk("arlen", ARLEN_M, len);
                  chk("arsize_burst_id", {ARSIZE_M, ARBURST_M, ARID_M}, {3'b010, 2'b01, 4'd0});
                  chk("rready_in_addr", RREADY_M, 0);
                  if (ARREADY_M) ph = 2;
               end
            end
            2: begin
               if (wr) begin
                  chk("wvalid_follow", WVALID_M, core_wvalid);
                  if (WVALID_M && WREADY_M) begin
                     chk("wdata", WDATA_M, dq[beat]);
                     chk("wstrb", WSTRB_M, strb);
                     chk("wlast", WLAST_M, (beat == nb - 1));
                     chk("core_wready", core_wready, 1);
                     beat++;
                     if (beat == nb) ph = 3;
                  end
               end else begin
                  chk("rready", RREADY_M, 1);
                  if (RVALID_M) begin
                     chk("core_rvalid", core_rvalid, 1);
                     chk("core_rdata", core_rdata, dq[beat]);
                     chk("core_rlast", core_rlast, (beat == nb - 1) && (mode != 3));
                     if (beat == abort_at) begin
                        ARESETn = 0;
                        #1;
                        chk("rst_rready", RREADY_M, 0);
                        chk("rst_arvalid", ARVALID_M, 0);
                        chk("rst_core_rvalid", core_rvalid, 0);
                        chk("rst_core_done", core_done, 0);
                        aborted = 1;
                        return;
                     end
                     beat++;
                     if (beat == nb) ph = 4;
                  end
               end
            end
            3: begin
               chk("bready", BREADY_M, 1);
               if (BVALID_M) ph = 4;
            end
            default: begin
               chk("core_done", core_done, 1);
               chk("core_resp", core_resp, exp_resp);
               chk("req_ready_in_done", req_ready, 0);
               ph = 5;
            end
         endcase
         if (ph != 4 && ph != 5) chk("done_low", core_done, 0);
         @(posedge ACLK);
         #1;
         req_valid = 0;
         idle_slave();
         case (ph)
            1: begin
               if (wr) begin
                  AWREADY_M   = (wait_a == 0);
                  core_wvalid = 1'($urandom_range(0, 1));
                  core_wdata  = dq[0];
               end else begin
                  ARREADY_M = (wait_a == 0);
               end
               if (wait_a > 0) wait_a--;
            end
            2: begin
               if (wr) begin
                  core_wvalid = ($urandom_range(0, 3) != 0);
                  core_wdata  = dq[beat];
                  WREADY_M    = ($urandom_range(0, 3) != 0);
               end else begin
                  RVALID_M = ($urandom_range(0, 3) != 0);
                  RDATA_M  = dq[beat];
                  RLAST_M  = (beat == nb - 1) && (mode != 3);
                  RRESP_M  = (mode == 1 && beat == bad_beat) ? 2'b10 : 2'b00;
                  RID_M    = (mode == 2 && beat == bad_beat) ? 4'd5 : 4'd0;
               end
            end
            3: begin
               BVALID_M = (wait_b == 0);
               BRESP_M  = (mode == 1) ? 2'b10 : 2'b00;
               BID_M    = (mode == 2) ? 4'd5 : 4'd0;
               if (wait_b > 0) wait_b--;
            end
            default: ;
         endcase
      end
      chk("txn_complete_phase", ph, 5);
      @(negedge ACLK);
      chk("req_ready_after_done", req_ready, 1);
      chk("done_single_cycle", core_done, 0);
      @(posedge ACLK);
      #1;
   endtask

   typedef struct {
      bit          wr;
      logic [31:0] addr;
      logic [3:0]  len;
      logic [3:0]  strb;
      int          mode;
      logic [1:0]  exp_resp;
   } vec_t;

   vec_t vecs[10];
   bit   ab;

   initial begin
      vecs[0] = '{0, 32'h0000_0010, 4'd0,  4'hF, 0, 2'b00};
      vecs[1] = '{0, 32'h0000_0100, 4'd3,  4'hF, 0, 2'b00};
      vecs[2] = '{1, 32'h0000_0200, 4'd2,  4'h3, 0, 2'b00};
      vecs[3] = '{1, 32'h0000_0300, 4'd0,  4'hF, 1, 2'b10};
      vecs[4] = '{0, 32'h0000_0040, 4'd1,  4'hF, 2, 2'b10};
      vecs[5] = '{0, 32'h0000_0080, 4'd15, 4'hF, 0, 2'b00};
      vecs[6] = '{1, 32'h0000_0400, 4'd15, 4'hC, 0, 2'b00};
      vecs[7] = '{0, 32'h0000_0500, 4'd2,  4'hF, 3, 2'b10};
      vecs[8] = '{1, 32'h0000_0600, 4'd1,  4'h5, 2, 2'b10};
      vecs[9] = '{0, 32'h0000_0700, 4'd4,  4'hF, 1, 2'b10};

      ARESETn = 0;
      req_valid = 0; req_write = 0; req_addr = '0; req_len = '0; req_wstrb = '0;
      idle_slave();
      repeat (3) @(posedge ACLK);
      #1;
      chk("rst_valids", {ARVALID_M, AWVALID_M, WVALID_M}, 0);
      chk("rst_readys", {RREADY_M, BREADY_M}, 0);
      chk("rst_done_resp", {core_done, core_resp}, 0);
      chk("rst_addr_len", {ARADDR_M, ARLEN_M, AWLEN_M}, 0);
      chk("rst_awaddr_wstrb", {AWADDR_M, WSTRB_M}, 0);
      ARESETn = 1;
      @(posedge ACLK);
      #1;

      for (int i = 0; i < 10; i++) begin
         do_txn(vecs[i].wr, vecs[i].addr, vecs[i].len, vecs[i].strb,
                vecs[i].mode, vecs[i].exp_resp, -1, ab);
      end

      // Stray responses while idle are never accepted.
      RVALID_M = 1; BVALID_M = 1; WREADY_M = 1; core_wvalid = 1;
      @(negedge ACLK);
      chk("stray_rready", RREADY_M, 0);
      chk("stray_bready", BREADY_M, 0);
      chk("stray_core_rvalid", core_rvalid, 0);
      chk("stray_wvalid", WVALID_M, 0);
      @(posedge ACLK);
      #1;
      idle_slave();
      @(negedge ACLK);
      chk("stray_still_idle", req_ready, 1);
      @(posedge ACLK);
      #1;

      // Reset during beat 2 of an 8-beat read, then a clean read.
      do_txn(0, 32'h0000_0800, 4'd7, 4'hF, 0, 2'b00, 2, ab);
      chk("abort_reached", ab, 1);
      repeat (2) @(posedge ACLK);
      #1;
      idle_slave();
      ARESETn = 1;
      @(negedge ACLK);
      chk("post_reset_req_ready", req_ready, 1);
      chk("post_reset_arlen", ARLEN_M, 0);
      @(posedge ACLK);
      #1;
      do_txn(0, 32'h0000_0900, 4'd3, 4'hF, 0, 2'b00, -1, ab);

      // Randomised transactions against the reference rule.
      for (int i = 0; i < 25; i++) begin
         bit          wr;
         int          mode;
         logic [31:0] a;
         wr   = 1'($urandom_range(0, 1));
         mode = $urandom_range(0, wr ? 2 : 3);
         a    = $urandom & 32'hFFFF_FFFC;
         do_txn(wr, a, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                mode, (mode != 0) ? 2'b10 : 2'b00, -1, ab);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
